// File: rtl/sr_ctrl_pkg.sv
// Shared encodings and width helpers for the serial shift sequencer.
// Counter widths depend on module parameters, so they come from helper functions.
package sr_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  function automatic int bit_cnt_w(input int width);
    return $clog2(width);
  endfunction

  function automatic int div_cnt_w(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

  // Widths for the default WIDTH=8, DIV=4 configuration.
  localparam int BIT_CNT_W = bit_cnt_w(8);
  localparam int DIV_CNT_W = div_cnt_w(4);

endpackage

// File: rtl/sr_tick_gen.sv
// Bit-period divider: tick is high on the last cycle of each DIV-cycle serial bit.
// clear has priority over en and holds the count at zero.
module sr_tick_gen
  import sr_ctrl_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clear,
  output logic tick
);

  localparam int CW = div_cnt_w(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] div_cnt_q, div_cnt_d;

  assign tick = en && (div_cnt_q == LAST);

  always_comb begin
    div_cnt_d = div_cnt_q;
    if (clear) begin
      div_cnt_d = '0;
    end else if (en) begin
      div_cnt_d = tick ? '0 : div_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) div_cnt_q <= '0;
    else     div_cnt_q <= div_cnt_d;
  end

endmodule

// File: rtl/sr_shift_ctrl.sv
// MSB-first serial shift sequencer: loads a word, shifts it out on so while
// capturing si into the LSB, then pulses rx_valid with the received word.
module sr_shift_ctrl
  import sr_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic             abort,
  input  logic             si,
  output logic             so,
  output logic             frame,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  localparam int BCW = bit_cnt_w(WIDTH);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             in_shift;
  logic             tick;
  logic [WIDTH-1:0] sr_shifted;

  assign in_shift   = (state_q == ST_SHIFT);
  assign sr_shifted = {sr_q[WIDTH-2:0], si};

  sr_tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk   (clk),
    .rst   (rst),
    .en    (in_shift),
    .clear (!in_shift),
    .tick  (tick)
  );

  // Handshake: a word transfers on any cycle where tx_valid && tx_ready;
  // tx_ready is high only in IDLE and does not depend on tx_valid.
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    rx_data_d = rx_data_q;
    case (state_q)
      ST_IDLE: begin
        if (tx_valid) begin
          sr_d      = tx_data;
          bit_cnt_d = '0;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          sr_d      = sr_shifted;
          bit_cnt_d = bit_cnt_q + BCW'(1);
          // Capture on the final tick so rx_data is already valid during DONE.
          if (bit_cnt_q == BIT_LAST) begin
            rx_data_d = sr_shifted;
            state_d   = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      rx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      rx_data_q <= rx_data_d;
    end
  end

  assign tx_ready  = (state_q == ST_IDLE);
  assign frame     = in_shift;
  assign so        = in_shift & sr_q[WIDTH-1];
  assign rx_valid  = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign rx_data   = rx_data_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_sr_shift_ctrl.sv
// Directed bench for sr_shift_ctrl: an 8-bit/DIV=4 instance and a 4-bit/DIV=1
// instance, with received words checked against a queue of expected words.
module tb_sr_shift_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;

  logic [7:0] tx_data_a, rx_data_a;
  logic       tx_valid_a, tx_ready_a, abort_a, si_a, so_a, frame_a, rx_valid_a, busy_a;
  logic [1:0] state_a;
  logic       loop_a, si_val_a;

  logic [3:0] tx_data_b, rx_data_b;
  logic       tx_valid_b, tx_ready_b, abort_b, si_b, so_b, frame_b, rx_valid_b, busy_b;
  logic [1:0] state_b;

  assign si_a = loop_a ? so_a : si_val_a;
  assign si_b = so_b;

  sr_shift_ctrl #(.WIDTH(8), .DIV(4)) dut_a (
    .clk(clk), .rst(rst), .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
    .abort(abort_a), .si(si_a), .so(so_a), .frame(frame_a), .rx_data(rx_data_a),
    .rx_valid(rx_valid_a), .busy(busy_a), .state_dbg(state_a)
  );

  sr_shift_ctrl #(.WIDTH(4), .DIV(1)) dut_b (
    .clk(clk), .rst(rst), .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
    .abort(abort_b), .si(si_b), .so(so_b), .frame(frame_b), .rx_data(rx_data_b),
    .rx_valid(rx_valid_b), .busy(busy_b), .state_dbg(state_b)
  );

  int n_pass  = 0;
  int n_total = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_rx(input string tag, input logic [7:0] obs);
    chk({tag, "_q_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) chk(tag, obs, exp_q.pop_front());
  endtask

  // Full frame on dut_a starting at cycle 0 (caller is in IDLE); optionally keeps
  // tx_valid asserted with next_d to exercise back-to-back and late-data changes.
  task automatic run_frame_a(input logic [7:0] d, input logic [7:0] exp_rx,
                             input logic hold, input logic [7:0] next_d);
    chk("accept_ready", tx_ready_a, 32'd1);
    tx_data_a  = d;
    tx_valid_a = 1'b1;
    exp_q.push_back(exp_rx);
    step();
    tx_valid_a = hold;
    tx_data_a  = next_d;
    for (int c = 1; c <= 32; c++) begin
      chk("shift_frame", frame_a, 32'd1);
      chk("shift_so", so_a, 32'(d[7 - (c - 1) / 4]));
      chk("shift_ready_low", tx_ready_a, 32'd0);
      chk("shift_busy", busy_a, 32'd1);
      chk("shift_no_rx_valid", rx_valid_a, 32'd0);
      step();
    end
    chk("done_rx_valid", rx_valid_a, 32'd1);
    chk("done_frame", frame_a, 32'd0);
    chk("done_ready_low", tx_ready_a, 32'd0);
    pop_rx("done_rx_data", rx_data_a);
    step();
    chk("post_ready", tx_ready_a, 32'd1);
    chk("post_rx_valid", rx_valid_a, 32'd0);
  endtask

  // Frame on dut_a cancelled by abort asserted at cycle 'at' of the frame.
  task automatic abort_frame_a(input logic [7:0] d, input int at, input logic [7:0] prev_rx);
    chk("abort_accept_ready", tx_ready_a, 32'd1);
    tx_data_a  = d;
    tx_valid_a = 1'b1;
    step();
    tx_valid_a = 1'b0;
    for (int c = 1; c < at; c++) begin
      chk("abort_pre_frame", frame_a, 32'd1);
      step();
    end
    chk("abort_cycle_frame", frame_a, 32'd1);
    abort_a = 1'b1;
    step();
    abort_a = 1'b0;
    chk("abort_frame_low", frame_a, 32'd0);
    chk("abort_busy_low", busy_a, 32'd0);
    chk("abort_ready", tx_ready_a, 32'd1);
    chk("abort_no_rx_valid", rx_valid_a, 32'd0);
    chk("abort_rx_held", rx_data_a, 32'(prev_rx));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_so"}, so_a, 32'd0);
    chk({tag, "_frame"}, frame_a, 32'd0);
    chk({tag, "_rx_valid"}, rx_valid_a, 32'd0);
    chk({tag, "_busy"}, busy_a, 32'd0);
    chk({tag, "_ready"}, tx_ready_a, 32'd1);
    chk({tag, "_rx_data"}, rx_data_a, 32'd0);
    chk({tag, "_state"}, state_a, 32'd0);
    chk({tag, "_b_ready"}, tx_ready_b, 32'd1);
    chk({tag, "_b_so"}, so_b, 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    tx_data_a  = '0;
    tx_valid_a = 1'b0;
    abort_a    = 1'b0;
    loop_a     = 1'b1;
    si_val_a   = 1'b0;
    tx_data_b  = '0;
    tx_valid_b = 1'b0;
    abort_b    = 1'b0;

    #1;
    chk_reset_outputs("reset");
    step();
    step();
    rst = 1'b0;
    step();

    // Loopback of A5.
    run_frame_a(8'hA5, 8'hA5, 1'b0, 8'h00);

    // si stuck high while sending zeros.
    loop_a   = 1'b0;
    si_val_a = 1'b1;
    run_frame_a(8'h00, 8'hFF, 1'b0, 8'h00);
    loop_a = 1'b1;

    // Back-to-back with tx_valid held; tx_data changes mid-frame are ignored.
    run_frame_a(8'h3C, 8'h3C, 1'b1, 8'hC3);
    run_frame_a(8'hC3, 8'hC3, 1'b0, 8'h00);

    // Abort mid-frame, then immediate re-accept on the next cycle.
    abort_frame_a(8'h5A, 10, 8'hC3);
    run_frame_a(8'h81, 8'h81, 1'b0, 8'h00);

    // Abort coinciding with the final tick wins over DONE.
    abort_frame_a(8'hE7, 32, 8'h81);
    step();
    chk("abort_last_no_done", rx_valid_a, 32'd0);

    // Asynchronous reset between clock edges mid-SHIFT.
    tx_data_a  = 8'h96;
    tx_valid_a = 1'b1;
    step();
    tx_valid_a = 1'b0;
    step();
    chk("pre_rst_so", so_a, 32'd1);
    chk("pre_rst_frame", frame_a, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("async_rst");
    step();
    rst = 1'b0;
    step();
    chk("post_rst_ready", tx_ready_a, 32'd1);
    run_frame_a(8'h69, 8'h69, 1'b0, 8'h00);

    // WIDTH=4, DIV=1 loopback of 9.
    chk("b_accept_ready", tx_ready_b, 32'd1);
    tx_data_b  = 4'h9;
    tx_valid_b = 1'b1;
    exp_q.push_back(8'h09);
    step();
    tx_valid_b = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      chk("b_frame", frame_b, 32'd1);
      chk("b_so", so_b, 32'(tx_data_b[4 - c]));
      chk("b_no_rx_valid", rx_valid_b, 32'd0);
      step();
    end
    chk("b_done_rx_valid", rx_valid_b, 32'd1);
    chk("b_done_frame", frame_b, 32'd0);
    pop_rx("b_rx_data", {4'h0, rx_data_b});
    step();
    chk("b_post_ready", tx_ready_b, 32'd1);
    chk("b_post_rx_valid", rx_valid_b, 32'd0);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
